uart_tx: RTL and testbench

UART transmitter: accepts one byte per valid/ready handshake and serialises it on `o_tx` as 8N1 (or 8E1 with parity compiled in), LSB first. Baud rate and clock source are selected at run time with the same 3-bit rate code and 1-bit clock code the UART receiver uses, so both ends of a link are configured identically. It sits between the host-side byte source and the TX pin of the 16550-style UART.

---
 rtl/uart_tx.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one byte per valid/ready handshake, sent LSB first.
// The default frame is 8N1. Define UART_TX_PARITY_EN to send 8E1 frames instead:
// an even parity bit goes between d[7] and the stop bit.
// The bit period is DIV = clock frequency / baud. The 3-bit rate code and the
// 1-bit clock code select it at run time. DIV is frozen when a byte is accepted.
//
// Ports:
//   i_sys_clk      system clock, rising edge
//   i_sys_rst_n    asynchronous active-low reset
//   i_tx_uart_bps  rate code 0..7 -> 2400,4800,9600,19200,38400,57600,115200,9600
//   i_tx_uart_clk  0 selects CLK_FREQ_0, 1 selects CLK_FREQ_1
//   i_data         byte to send, latched on acceptance
//   i_valid        byte available
//   o_ready        idle and able to accept a byte
//   o_tx           serial line, idles high
//   o_busy         inverse of o_ready
//   o_done         one-cycle pulse when the stop bit ends
module uart_tx #(
    parameter int unsigned CLK_FREQ_0 = 26_000_000,
    parameter int unsigned CLK_FREQ_1 = 50_000_000
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst_n,
    input  logic [2:0] i_tx_uart_bps,
    input  logic       i_tx_uart_clk,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WARM_W = 2;

    typedef logic [15:0][DIV_W-1:0] div_tab_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Elaboration-time divisor table indexed by {clock code, rate code}
    function automatic div_tab_t build_div_tab();
        div_tab_t    tab;
        int unsigned freq;
        int unsigned baud;
        tab = '0;
        for (int i = 0; i < 16; i++) begin
            freq = (i >= 8) ? CLK_FREQ_1 : CLK_FREQ_0;
            case (i % 8)
                0:       baud = 2400;
                1:       baud = 4800;
                2:       baud = 9600;
                3:       baud = 19200;
                4:       baud = 38400;
                5:       baud = 57600;
                6:       baud = 115200;
                default: baud = 9600;
            endcase
            tab[i] = DIV_W'(freq / baud);
        end
        return tab;
    endfunction

    localparam div_tab_t DIV_TAB = build_div_tab();

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif
    logic [DIV_W-1:0]    div_sel;
    logic                wrap;
    logic                warm_ok;

    assign div_sel = DIV_TAB[{i_tx_uart_clk, i_tx_uart_bps}];
    assign wrap    = (cnt_q == div_q - DIV_W'(1));
    // DIV is loaded on the first edge after reset; accept nothing until the third edge
    assign warm_ok = (warm_q == WARM_W'(2));

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        warm_d  = warm_ok ? warm_q : warm_q + WARM_W'(1);
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != S_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                div_d = div_sel;
                cnt_d = '0;
                bit_d = '0;
                tx_d  = 1'b1;
                if (i_valid && ready_q && warm_ok) begin
                    state_d = S_START;
                    shift_d = i_data;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^i_data;
`endif
                end
            end
            S_START: begin
                if (wrap) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (wrap) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (wrap) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (wrap) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == S_IDLE) && warm_ok;
        busy_d  = !ready_d;
    end

    // State and output registers
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            warm_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            warm_q  <= warm_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. The clock frequencies are scaled down so that every
// frame stays short. The reference model builds the expected frame as a list of
// bits and takes DIV from a baud table.
module tb_uart_tx;

    localparam int unsigned F0 = 250_000;
    localparam int unsigned F1 = 500_000;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] bps = 3'd0;
    logic       cs = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, busy, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;

    uart_tx #(.CLK_FREQ_0(F0), .CLK_FREQ_1(F1)) dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_tx_uart_bps (bps),
        .i_tx_uart_clk (cs),
        .i_data        (data),
        .i_valid       (valid),
        .o_ready       (ready),
        .o_tx          (tx),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_div(input logic [2:0] b, input logic c);
        int baud[8] = '{2400, 4800, 9600, 19200, 38400, 57600, 115200, 9600};
        return int'((c ? F1 : F0) / baud[b]);
    endfunction

    // Sends one byte and checks the whole frame cycle by cycle against the model.
    // mid_at (sample index, -1 for none) changes the rate code and clock code
    // mid-frame and can also pulse i_valid with 0xFF.
    task automatic send(input logic [7:0] d, input logic [2:0] b, input logic c,
                        input bit keep_valid, input int mid_at, input logic [2:0] mid_b,
                        input logic mid_c, input bit mid_pulse, output int t_acc);
        int div;
        int n;
        int bad;
        int ctl_bad;
        int s;
        logic [NB-1:0] bits;
        bps  = b;
        cs   = c;
        data = d;
        n = 0;
        while (ready !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        check("ready before send", 32'(ready), 32'd1);
        valid = 1'b1;
        step();
        t_acc = cyc;
        if (!keep_valid) valid = 1'b0;
        div = exp_div(b, c);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^d;
`endif
        bits[NB - 1] = 1'b1;
        ctl_bad = 0;
        for (int k = 0; k < NB; k++) begin
            bad = 0;
            for (int cc = 0; cc < div; cc++) begin
                s = k * div + cc;
                if (s == mid_at) begin
                    bps = mid_b;
                    cs  = mid_c;
                    if (mid_pulse) begin
                        valid = 1'b1;
                        data  = 8'hFF;
                    end
                end
                if (mid_pulse && s == mid_at + 1) valid = 1'b0;
                if (tx !== bits[k]) bad++;
                if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) ctl_bad++;
                step();
            end
            check($sformatf("wrong cycles in bit %0d of byte %02h", k, d), 32'(bad), 32'd0);
        end
        check($sformatf("ctl during frame %02h", d), 32'(ctl_bad), 32'd0);
        check($sformatf("done at end of %02h", d), 32'(done), 32'd1);
        check($sformatf("ready at end of %02h", d), 32'(ready), 32'd1);
        check($sformatf("busy at end of %02h", d), 32'(busy), 32'd0);
        check($sformatf("tx at end of %02h", d), 32'(tx), 32'd1);
        if (!keep_valid) begin
            step();
            check($sformatf("done one cycle after %02h", d), 32'(done), 32'd0);
            check($sformatf("idle tx after %02h", d), 32'(tx), 32'd1);
        end
    endtask

    initial begin
        int t1;
        int t2;
        int dc;
        int bad;
        logic [7:0] rd;
        logic [2:0] rb;
        logic       rc;

        // Reset values
        repeat (5) step();
        check("reset tx", 32'(tx), 32'd1);
        check("reset ready", 32'(ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("warmup ready edge1", 32'(ready), 32'd0);
        step();
        check("warmup ready edge2", 32'(ready), 32'd0);
        step();
        check("warmup ready edge3", 32'(ready), 32'd1);
        check("warmup tx", 32'(tx), 32'd1);

        // Single frame: clk=1, bps=6
        dc = done_cnt;
        send(8'h55, 3'd6, 1'b1, 1'b0, -1, 3'd0, 1'b0, 1'b0, t1);
        check("single frame done count", 32'(done_cnt - dc), 32'd1);

        // Back-to-back with i_valid held high
        send(8'hA3, 3'd2, 1'b0, 1'b1, -1, 3'd0, 1'b0, 1'b0, t1);
        send(8'h0F, 3'd2, 1'b0, 1'b0, -1, 3'd0, 1'b0, 1'b0, t2);
        check("back-to-back period", 32'(t2 - t1), 32'(NB * exp_div(3'd2, 1'b0) + 1));

        // Rate change mid-frame keeps the current frame's DIV
        send(8'hC4, 3'd2, 1'b0, 1'b0, 5 * exp_div(3'd2, 1'b0) + 3, 3'd6, 1'b0, 1'b0, t1);
        send(8'h3B, 3'd6, 1'b0, 1'b0, -1, 3'd0, 1'b0, 1'b0, t1);

        // Valid pulse while busy is ignored
        dc = done_cnt;
        send(8'h00, 3'd3, 1'b1, 1'b0, 20, 3'd3, 1'b1, 1'b1, t1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1 || ready !== 1'b1) bad++;
            step();
        end
        check("no queued byte after ignored valid", 32'(bad), 32'd0);
        check("ignored valid done count", 32'(done_cnt - dc), 32'd1);

        // Parity-sensitive bytes
        send(8'h07, 3'd4, 1'b1, 1'b0, -1, 3'd0, 1'b0, 1'b0, t1);
        send(8'h03, 3'd4, 1'b1, 1'b0, -1, 3'd0, 1'b0, 1'b0, t1);

        // Random frames
        for (int r = 0; r < 8; r++) begin
            rd = 8'($urandom);
            rb = 3'($urandom_range(0, 7));
            rc = 1'($urandom);
            send(rd, rb, rc, 1'b0, -1, 3'd0, 1'b0, 1'b0, t1);
        end

        // Reset in the middle of a frame
        data  = 8'h00;
        bps   = 3'd5;
        cs    = 1'b0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (10) step();
        check("mid-frame line low", 32'(tx), 32'd0);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx", 32'(tx), 32'd1);
        check("async reset ready", 32'(ready), 32'd1);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        step();
        step();
        #2 rst_n = 1'b1;
        repeat (3) step();
        check("ready after reset recovery", 32'(ready), 32'd1);
        check("no done from abandoned frame", 32'(done_cnt - dc), 32'd0);
        send(8'h96, 3'd6, 1'b1, 1'b0, -1, 3'd0, 1'b0, 1'b0, t1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
